trace_cmd_issuer: RTL and testbench

- Producer end of the cache-simulation command interface. Accepts parsed trace entries (command, address) on a valid/ready input stream and buffers them in a small FIFO.
- Drives command/address/mode/done into the data and instruction caches, one command per clock.
- Filters illegal opcodes, inserts idle gaps after PRINT, and asserts done once the last trace entry has been issued.

---
 rtl/trace_cmd_issuer.sv | 176 +++++++++++++++++
 tb/tb_trace_cmd_issuer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/trace_cmd_issuer.sv
// rtl/trace_cmd_issuer.sv - trace command issuer: buffers trace entries and drives one cache command per clock
module trace_cmd_issuer #(
   parameter int         ADDR_W     = 32,
   parameter int         FIFO_DEPTH = 4,
   parameter int         PRINT_GAP  = 2,
   parameter logic [3:0] IDLE_CMD   = 4'hF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_command,
   input  logic [ADDR_W-1:0] in_address,
   input  logic              in_last,
   output logic [3:0]        command,
   output logic [ADDR_W-1:0] address,
   output logic              mode,
   output logic              done,
   output logic              busy,
   output logic [15:0]       issued_count,
   output logic [7:0]        bad_cmd_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = 4 + ADDR_W + 1;
   localparam int GW = (PRINT_GAP < 2) ? 1 : $clog2(PRINT_GAP + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [EW-1:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]       cnt_q, cnt_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              mode_q, mode_d, done_q, done_d, busy_q, busy_d;
   logic              fin_q, fin_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [15:0]       issued_q, issued_d;
   logic [7:0]        bad_q, bad_d;
   logic              push, pop, empty, full;
   logic [EW-1:0]     entry;
   logic [3:0]        ent_cmd;
   logic [ADDR_W-1:0] ent_addr;
   logic              ent_last;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == (PW+1)'(FIFO_DEPTH));
   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign entry    = mem[rd_ptr_q];
   assign ent_cmd  = entry[EW-1 -: 4];
   assign ent_addr = entry[ADDR_W:1];
   assign ent_last = entry[0];

   assign command       = cmd_q;
   assign address       = addr_q;
   assign mode          = mode_q;
   assign done          = done_q;
   assign busy          = busy_q;
   assign issued_count  = issued_q;
   assign bad_cmd_count = bad_q;

   // Buffer storage; contents need no reset because occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {in_command, in_address, in_last};
   end

   // FIFO pointer and occupancy update; pointers wrap naturally at power-of-two depth
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + (PW+1)'(1);
      else if (!push && pop) cnt_d = cnt_q - (PW+1)'(1);
   end

   // Issue FSM next state; fin marks a popped last entry so DONE follows its issue cycle
   always_comb begin
      state_d  = state_q;
      cmd_d    = IDLE_CMD;
      addr_d   = addr_q;
      mode_d   = mode_q;
      done_d   = done_q;
      fin_d    = fin_q;
      gap_d    = gap_q;
      issued_d = issued_q;
      bad_d    = bad_q;
      pop      = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               mode_d   = mode_in;
               issued_d = '0;
               bad_d    = '0;
               done_d   = 1'b0;
               fin_d    = 1'b0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (fin_q) begin
               fin_d   = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (!empty) begin
               pop = 1'b1;
               if (is_legal(ent_cmd)) begin
                  cmd_d  = ent_cmd;
                  addr_d = ent_addr;
                  if (issued_q != 16'hFFFF) issued_d = issued_q + 16'd1;
               end else if (bad_q != 8'hFF) begin
                  bad_d = bad_q + 8'd1;
               end
               if (ent_last) begin
                  fin_d = 1'b1;
               end else if (ent_cmd == 4'd9 && PRINT_GAP > 0) begin
                  gap_d   = GW'(PRINT_GAP);
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - GW'(1);
            if (gap_q <= GW'(1)) state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_RUN) || (state_d == S_GAP);
   end

   // State, FIFO pointers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         cmd_q    <= IDLE_CMD;
         addr_q   <= '0;
         mode_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         fin_q    <= 1'b0;
         gap_q    <= '0;
         issued_q <= '0;
         bad_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         mode_q   <= mode_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         fin_q    <= fin_d;
         gap_q    <= gap_d;
         issued_q <= issued_d;
         bad_q    <= bad_d;
      end
   end

endmodule

// File: tb/tb_trace_cmd_issuer.sv
// tb/tb_trace_cmd_issuer.sv - directed self-checking bench for trace_cmd_issuer
module tb_trace_cmd_issuer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, mode_in, in_valid, in_ready, in_last;
   logic [3:0]  in_command, command;
   logic [31:0] in_address, address;
   logic        mode, done, busy;
   logic [15:0] issued_count;
   logic [7:0]  bad_cmd_count;

   int n_total = 0;
   int n_pass  = 0;

   trace_cmd_issuer #(.ADDR_W(32), .FIFO_DEPTH(4), .PRINT_GAP(2), .IDLE_CMD(4'hF)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_command(in_command),
      .in_address(in_address), .in_last(in_last), .command(command),
      .address(address), .mode(mode), .done(done), .busy(busy),
      .issued_count(issued_count), .bad_cmd_count(bad_cmd_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [3:0] c, input logic [31:0] a, input logic l);
      in_command = c; in_address = a; in_last = l; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pulse_start(input logic m);
      start = 1'b1; mode_in = m;
      tick();
      start = 1'b0;
   endtask

   logic [3:0]  seq_cmd  [5] = '{4'h0, 4'h9, 4'hF, 4'hF, 4'h1};
   logic [3:0]  bad_seq  [3] = '{4'hF, 4'hF, 4'h0};
   logic [3:0]  bp_cmd   [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8};
   logic [35:0] got_q [$];
   int          idx;
   logic        acc;

   task automatic drive_bp(input int i);
      in_command = bp_cmd[i];
      in_address = 32'h1000 + 32'(i * 4);
      in_last    = (i == 5);
      in_valid   = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mode_in = 1'b0; in_valid = 1'b0;
      in_command = 4'h0; in_address = '0; in_last = 1'b0;
      #12;
      check("rst_cmd", command, 4'hF);
      check("rst_addr", address, 0);
      check("rst_flags", {mode, done, busy, in_ready}, 4'b0001);
      check("rst_cnts", {issued_count, bad_cmd_count}, 0);
      rst_n = 1'b1;
      tick();

      // Basic streaming issue in RUN
      pulse_start(1'b1);
      check("t1_busy_mode", {busy, mode}, 2'b11);
      in_command = 4'h0; in_address = 32'h10; in_last = 1'b0; in_valid = 1'b1;
      tick();
      check("t1_first_idle", command, 4'hF);
      in_command = 4'h1; in_address = 32'h20;
      tick();
      check("t1_read", {command, address}, {4'h0, 32'h10});
      in_command = 4'h2; in_address = 32'h30; in_last = 1'b1;
      tick();
      check("t1_write", {command, address}, {4'h1, 32'h20});
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      check("t1_ifetch", {command, address}, {4'h2, 32'h30});
      check("t1_not_done_yet", done, 1'b0);
      tick();
      check("t1_done", {done, busy, command}, {1'b1, 1'b0, 4'hF});
      check("t1_issued", issued_count, 3);
      check("t1_addr_hold", address, 32'h30);

      // PRINT gap, preloaded in DONE, second start restarts counters
      preload(4'h0, 32'h40, 1'b0);
      preload(4'h9, 32'h44, 1'b0);
      preload(4'h1, 32'h48, 1'b1);
      check("t2_still_done", done, 1'b1);
      pulse_start(1'b0);
      check("t2_restart", {done, busy, mode, issued_count}, {1'b0, 1'b1, 1'b0, 16'd0});
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t2_seq%0d", i), command, seq_cmd[i]);
      end
      check("t2_write_addr", address, 32'h48);
      tick();
      check("t2_done", {done, issued_count, bad_cmd_count}, {1'b1, 16'd3, 8'd0});

      // Illegal opcodes dropped
      preload(4'h5, 32'h100, 1'b0);
      preload(4'hA, 32'h104, 1'b0);
      preload(4'h0, 32'h4, 1'b1);
      pulse_start(1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t3_seq%0d", i), command, bad_seq[i]);
         if (i == 0) check("t3_addr_hold", address, 32'h48);
      end
      check("t3_read_addr", address, 32'h4);
      tick();
      check("t3_counts", {done, issued_count, bad_cmd_count}, {1'b1, 16'd1, 8'd2});

      // Backpressure from IDLE
      rst_n = 1'b0; #1; rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_bp(i);
         tick();
      end
      check("t4_full", in_ready, 1'b0);
      check("t4_idle_no_issue", {command, busy}, {4'hF, 1'b0});
      idx = 4;
      drive_bp(4);
      pulse_start(1'b0);
      check("t4_full_after_start", in_ready, 1'b0);
      got_q = {};
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         acc = in_valid && in_ready;
         tick();
         if (command != 4'hF) got_q.push_back({command, address});
         if (acc) begin
            idx++;
            if (idx < 6) drive_bp(idx);
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      check("t4_done", done, 1'b1);
      check("t4_count", got_q.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < got_q.size())
            check($sformatf("t4_e%0d", i), got_q[i], {bp_cmd[i], 32'h1000 + 32'(i * 4)});
         else
            check($sformatf("t4_e%0d", i), 36'h0, {bp_cmd[i], 32'h1000 + 32'(i * 4)});
      end

      // Reset mid-run
      pulse_start(1'b1);
      for (int i = 0; i < 3; i++) begin
         in_command = 4'h1; in_address = 32'h200 + 32'(i * 4); in_last = 1'b0; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      check("t5_two_issued", issued_count, 2);
      rst_n = 1'b0;
      #1;
      check("t5_rst_cmd_busy", {command, busy}, {4'hF, 1'b0});
      check("t5_rst_outs", {address, mode, done, in_ready}, {32'h0, 1'b0, 1'b0, 1'b1});
      @(posedge clk); #3;
      rst_n = 1'b1;
      tick();
      tick();
      check("t5_idle", {busy, command, issued_count}, {1'b0, 4'hF, 16'd0});
      pulse_start(1'b0);
      for (int i = 0; i < 3; i++) tick();
      check("t5_fifo_empty", {command, issued_count, bad_cmd_count, done}, {4'hF, 16'd0, 8'd0, 1'b0});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
